// File: rtl/execute_scheduler_if.sv
// ============================================================================
// Module      : execute_scheduler_if
// Description : Issue / result bundle between an issuing stage and the
//               vector execute scheduler.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface execute_scheduler_if #(
  parameter int vecSize = 4,
  parameter int regSize = 8
);
  // Issue side
  logic                             flush;
  logic                             in_valid;
  logic                             in_ready;
  logic [2:0]                       ExecuteOp;
  logic [2:0]                       pcWrEn;
  logic                             overwriteFlags;
  logic [vecSize-1:0][regSize-1:0]  vect1;
  logic [vecSize-1:0][regSize-1:0]  vect2;

  // Result side
  logic                             out_valid;
  logic                             out_ready;
  logic [vecSize-1:0][regSize-1:0]  vectOut;
  logic                             pcWrEnOut;
  logic [1:0]                       NZ_flags;
  logic                             busy;

  // Issuing stage / consumer
  modport master (
    output flush, in_valid, ExecuteOp, pcWrEn, overwriteFlags, vect1, vect2,
           out_ready,
    input  in_ready, out_valid, vectOut, pcWrEnOut, NZ_flags, busy
  );

  // Scheduler
  modport slave (
    input  flush, in_valid, ExecuteOp, pcWrEn, overwriteFlags, vect1, vect2,
           out_ready,
    output in_ready, out_valid, vectOut, pcWrEnOut, NZ_flags, busy
  );
endinterface

`default_nettype wire

// File: rtl/execute_scheduler.sv
// ============================================================================
// Module      : execute_scheduler
// Description : Vector execute stage. Single-cycle lane-parallel ALU for
//               most ops; multiply runs lane-serially on one shared
//               regSize x regSize multiplier. Holds the architectural NZ
//               flags and resolves conditional branches.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module execute_scheduler #(
  parameter int vecSize = 4,
  parameter int regSize = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,     // asynchronous, active low
  execute_scheduler_if.slave     bus
);

  typedef logic [vecSize-1:0][regSize-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [2:0]         OP_PASS_A = 3'b000;
  localparam logic [2:0]         OP_XOR    = 3'b001;
  localparam logic [2:0]         OP_ADD    = 3'b010;
  localparam logic [2:0]         OP_SUB    = 3'b011;
  localparam logic [2:0]         OP_MUL    = 3'b100;
  localparam logic [2:0]         OP_SHR    = 3'b101;
  localparam logic [2:0]         OP_SHL    = 3'b110;
  localparam logic [2:0]         OP_PASS_B = 3'b111;

  localparam int                 CNT_W       = (vecSize > 1) ? $clog2(vecSize) : 1;
  localparam logic [CNT_W-1:0]   LAST_LANE   = CNT_W'(vecSize - 1);
  localparam logic [regSize:0]   SHIFT_LIMIT = (regSize + 1)'(regSize);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              state;
  logic [CNT_W-1:0]    lane_cnt;
  logic                out_valid_q;
  vec_t                vect_out_q;
  logic                pc_out_q;
  logic [1:0]          nz_q;

  // Operands of the in-flight multiply
  vec_t                op_a;
  vec_t                op_b;
  logic [2:0]          op_pcw;
  logic                op_ovw;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // Shift by a per-lane amount; any amount of regSize or more clears the lane.
  function automatic logic [regSize-1:0] shift_lane(
    input logic [regSize-1:0] a,
    input logic [regSize-1:0] amt,
    input logic               left
  );
    if ({1'b0, amt} >= SHIFT_LIMIT) begin
      return '0;
    end
    return left ? (a << amt) : (a >> amt);
  endfunction

  // {N, Z}: N = any lane negative, Z = every lane zero.
  function automatic logic [1:0] vec_flags(input vec_t v);
    logic n;
    logic z;
    n = 1'b0;
    z = 1'b1;
    for (int i = 0; i < vecSize; i++) begin
      n = n | v[i][regSize-1];
      z = z & (v[i] == '0);
    end
    return {n, z};
  endfunction

  // Branch decision from the jump mask and the flags the op sees.
  function automatic logic branch_taken(input logic [2:0] pcw, input logic [1:0] nz);
    return pcw[2] | (pcw[1] & nz[0]) | (pcw[0] & nz[1]);
  endfunction

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic issue_ready;
  logic accept;

  assign issue_ready = reset && !bus.flush &&
                       ((state == IDLE) || ((state == OUT) && bus.out_ready));
  assign accept      = issue_ready && bus.in_valid;

  // --------------------------------------------------------------------------
  // Single-cycle lane-parallel ALU (multiply is handled by the serial path)
  // --------------------------------------------------------------------------
  vec_t alu_vec;

  for (genvar i = 0; i < vecSize; i++) begin : g_lane
    logic [regSize-1:0] a;
    logic [regSize-1:0] b;
    logic [regSize-1:0] res;

    assign a = bus.vect1[i];
    assign b = bus.vect2[i];

    // Per-lane result for the issuing op, wrapping modulo 2^regSize.
    always_comb begin
      res = '0;
      case (bus.ExecuteOp)
        OP_PASS_A: res = a;
        OP_XOR:    res = a ^ b;
        OP_ADD:    res = a + b;
        OP_SUB:    res = a - b;
        OP_SHR:    res = shift_lane(a, b, 1'b0);
        OP_SHL:    res = shift_lane(a, b, 1'b1);
        OP_PASS_B: res = b;
        default:   res = '0;
      endcase
    end

    assign alu_vec[i] = res;
  end

  logic [1:0] alu_flags;
  logic [1:0] alu_branch_nz;

  assign alu_flags     = vec_flags(alu_vec);
  assign alu_branch_nz = bus.overwriteFlags ? alu_flags : nz_q;

  // --------------------------------------------------------------------------
  // Shared lane-serial multiplier
  // --------------------------------------------------------------------------
  logic [regSize-1:0] mul_lane;
  vec_t               mul_vec;
  logic [1:0]         mul_flags;
  logic [1:0]         mul_branch_nz;

  assign mul_lane = op_a[lane_cnt] * op_b[lane_cnt];

  // Result vector as it will look once the current lane is written; on the
  // last lane this is the complete product used for the flags.
  always_comb begin
    mul_vec           = vect_out_q;
    mul_vec[lane_cnt] = mul_lane;
  end

  assign mul_flags     = vec_flags(mul_vec);
  assign mul_branch_nz = op_ovw ? mul_flags : nz_q;

  // --------------------------------------------------------------------------
  // Control FSM and result registers
  // --------------------------------------------------------------------------
  // All outputs are registered here; accept in IDLE or a draining OUT starts
  // the next op directly so back-to-back issue needs no bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lane_cnt    <= '0;
      out_valid_q <= 1'b0;
      vect_out_q  <= '0;
      pc_out_q    <= 1'b0;
      nz_q        <= 2'b00;
      op_a        <= '0;
      op_b        <= '0;
      op_pcw      <= 3'b000;
      op_ovw      <= 1'b0;
    end else if (bus.flush) begin
      // Abort: flags keep their value, partial multiply results are dropped.
      state       <= IDLE;
      lane_cnt    <= '0;
      out_valid_q <= 1'b0;
      pc_out_q    <= 1'b0;
    end else if (accept) begin
      op_pcw <= bus.pcWrEn;
      op_ovw <= bus.overwriteFlags;
      if (bus.ExecuteOp == OP_MUL) begin
        state       <= MUL;
        lane_cnt    <= '0;
        out_valid_q <= 1'b0;
        pc_out_q    <= 1'b0;
        op_a        <= bus.vect1;
        op_b        <= bus.vect2;
      end else begin
        state       <= OUT;
        out_valid_q <= 1'b1;
        vect_out_q  <= alu_vec;
        pc_out_q    <= branch_taken(bus.pcWrEn, alu_branch_nz);
        if (bus.overwriteFlags) begin
          nz_q <= alu_flags;
        end
      end
    end else begin
      case (state)
        MUL: begin
          vect_out_q[lane_cnt] <= mul_lane;
          if (lane_cnt == LAST_LANE) begin
            state       <= OUT;
            lane_cnt    <= '0;
            out_valid_q <= 1'b1;
            pc_out_q    <= branch_taken(op_pcw, mul_branch_nz);
            if (op_ovw) begin
              nz_q <= mul_flags;
            end
          end else begin
            lane_cnt <= lane_cnt + CNT_W'(1);
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            pc_out_q    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = issue_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.vectOut   = vect_out_q;
  assign bus.pcWrEnOut = pc_out_q;
  assign bus.NZ_flags  = nz_q;
  assign bus.busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_execute_scheduler.sv
// ============================================================================
// Module      : tb_execute_scheduler
// Description : Self-checking bench for execute_scheduler: directed cases
//               plus randomized ops against an arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_execute_scheduler;

  localparam int VS = 4;
  localparam int RS = 8;

  typedef logic [VS-1:0][RS-1:0] vec_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  execute_scheduler_if #(.vecSize(VS), .regSize(RS)) bus ();

  execute_scheduler #(.vecSize(VS), .regSize(RS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [1:0] m_nz;
  vec_t       exp_vec;
  logic       exp_pc;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One lane of the architectural operation, in plain integer arithmetic.
  function automatic int ref_lane(input int op, input int a, input int b);
    int m;
    m = (1 << RS) - 1;
    case (op)
      0:       return a;
      1:       return a ^ b;
      2:       return (a + b) & m;
      3:       return (a - b) & m;
      4:       return (a * b) & m;
      5:       return (b >= RS) ? 0 : (a >> b);
      6:       return (b >= RS) ? 0 : ((a << b) & m);
      default: return b;
    endcase
  endfunction

  // Predict result vector, branch, and new architectural flags.
  task automatic model_op(input logic [2:0] op, input logic [2:0] pcw, input logic ovw,
                          input vec_t v1, input vec_t v2);
    logic n, z, bn, bz;
    n = 1'b0;
    z = 1'b1;
    for (int i = 0; i < VS; i++) begin
      exp_vec[i] = RS'(ref_lane(int'(op), int'(v1[i]), int'(v2[i])));
      if (int'(exp_vec[i]) >= (1 << (RS - 1))) n = 1'b1;
      if (exp_vec[i] != 0) z = 1'b0;
    end
    bn = ovw ? n : m_nz[1];
    bz = ovw ? z : m_nz[0];
    exp_pc = pcw[2] | (pcw[1] & bz) | (pcw[0] & bn);
    if (ovw) m_nz = {n, z};
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] pcw, input logic ovw,
                       input vec_t v1, input vec_t v2);
    bus.ExecuteOp      = op;
    bus.pcWrEn         = pcw;
    bus.overwriteFlags = ovw;
    bus.vect1          = v1;
    bus.vect2          = v2;
    bus.in_valid       = 1'b1;
  endtask

  // Issue from IDLE (called at a negedge); returns at the negedge where the
  // result is first visible, with out_ready still low.
  task automatic issue(input logic [2:0] op, input logic [2:0] pcw, input logic ovw,
                       input vec_t v1, input vec_t v2);
    int wait_cycles;
    model_op(op, pcw, ovw, v1, v2);
    bus.out_ready = 1'b0;
    drive(op, pcw, ovw, v1, v2);
    #1;
    check_value("in_ready_idle", bus.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_cycles = (op == 3'b100) ? VS : 0;
    for (int k = 0; k < wait_cycles; k++) begin
      check_value("mul_wait{ov,ir,busy}", {bus.out_valid, bus.in_ready, bus.busy}, 3'b001);
      @(negedge clk);
    end
    check_value("out_valid", bus.out_valid, 1'b1);
    check_value("vectOut", bus.vectOut, exp_vec);
    check_value("pcWrEnOut", bus.pcWrEnOut, exp_pc);
    check_value("NZ_flags", bus.NZ_flags, m_nz);
    check_value("busy_out", bus.busy, 1'b1);
  endtask

  // Hold the result for some cycles, then take it.
  task automatic consume(input int hold);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_value("hold_vectOut", {bus.out_valid, bus.vectOut}, {1'b1, exp_vec});
      check_value("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_value("drained{ov,pc,busy}", {bus.out_valid, bus.pcWrEnOut, bus.busy}, 3'b000);
  endtask

  // Start a multiply and return at its second MUL-cycle negedge.
  task automatic start_mul(input vec_t v1, input vec_t v2);
    bus.out_ready = 1'b0;
    drive(3'b100, 3'b000, 1'b1, v1, v2);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, v1, v2;
    logic pa;

    reset              = 1'b0;
    bus.flush          = 1'b0;
    bus.in_valid       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.ExecuteOp      = 3'b000;
    bus.pcWrEn         = 3'b000;
    bus.overwriteFlags = 1'b0;
    bus.vect1          = '0;
    bus.vect2          = '0;
    m_nz               = 2'b00;

    // Reset state
    #1;
    check_value("reset_outputs", {bus.out_valid, bus.vectOut, bus.pcWrEnOut, bus.NZ_flags,
                                  bus.busy, bus.in_ready}, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // XOR example
    issue(3'b001, 3'b000, 1'b1, 32'h55AACC33, 32'hAA55F00F);
    check_value("xor_vec", bus.vectOut, 32'hFFFF3C3C);
    check_value("xor_nz", bus.NZ_flags, 2'b10);
    consume(0);

    // MUL example
    issue(3'b100, 3'b000, 1'b1, 32'h050A0C03, 32'h0A05000F);
    check_value("mul_vec", bus.vectOut, 32'h3232002D);
    consume(1);

    // SUB to zero with jump-if-Z
    issue(3'b011, 3'b010, 1'b1, 32'h12345678, 32'h12345678);
    check_value("subz_vec", bus.vectOut, 32'h0);
    check_value("subz_nz", bus.NZ_flags, 2'b01);
    check_value("subz_pc", bus.pcWrEnOut, 1'b1);
    consume(0);
    issue(3'b011, 3'b000, 1'b1, 32'h00000000, 32'h01010101);
    consume(0);
    issue(3'b011, 3'b010, 1'b0, 32'h12345678, 32'h12345678);
    check_value("subz_noflag_pc", bus.pcWrEnOut, 1'b0);
    check_value("subz_noflag_nz", bus.NZ_flags, 2'b10);
    consume(0);

    // Shifts
    issue(3'b101, 3'b000, 1'b0, 32'h0FF055AA, 32'h04030201);
    check_value("shr_vec", bus.vectOut, 32'h001E1555);
    consume(0);
    issue(3'b110, 3'b000, 1'b0, 32'h11223344, 32'h08010007);
    check_value("shl8_lane", bus.vectOut[3], 8'h00);
    consume(0);

    // Backpressure with a waiting issue, then back-to-back accept
    issue(3'b010, 3'b100, 1'b1, 32'h01020304, 32'h10203040);
    va = exp_vec;
    pa = exp_pc;
    v1 = 32'h80FF0001;
    v2 = 32'h01010101;
    drive(3'b001, 3'b001, 1'b1, v1, v2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_value("bp_hold", {bus.out_valid, bus.in_ready, bus.vectOut, bus.pcWrEnOut},
                  {1'b1, 1'b0, va, pa});
    end
    model_op(3'b001, 3'b001, 1'b1, v1, v2);
    bus.out_ready = 1'b1;
    #1;
    check_value("bp_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_value("b2b_valid", bus.out_valid, 1'b1);
    check_value("b2b_vec", bus.vectOut, exp_vec);
    check_value("b2b_pc", bus.pcWrEnOut, exp_pc);
    check_value("b2b_nz", bus.NZ_flags, m_nz);
    consume(0);

    // Flush during MUL cycle 2: flags untouched, nothing completes
    start_mul(32'h80808080, 32'h01010101);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check_value("flush{ov,ir,busy}", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    check_value("flush_nz", bus.NZ_flags, m_nz);
    for (int k = 0; k < VS + 1; k++) begin
      @(negedge clk);
      check_value("flush_quiet", {bus.out_valid, bus.NZ_flags}, {1'b0, m_nz});
    end

    // Asynchronous reset mid-MUL
    issue(3'b111, 3'b000, 1'b1, 32'h0, 32'hF1F2F3F4);
    consume(0);
    start_mul(32'h03030303, 32'h05050505);
    #2;
    reset = 1'b0;
    #1;
    check_value("async_reset", {bus.out_valid, bus.vectOut, bus.pcWrEnOut, bus.NZ_flags,
                                bus.busy, bus.in_ready}, '0);
    m_nz = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Randomized ops against the model
    for (int t = 0; t < 40; t++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      for (int i = 0; i < VS; i++) begin
        v1[i] = RS'($urandom);
        v2[i] = ($urandom_range(0, 1) == 1) ? RS'($urandom_range(0, RS + 2)) : RS'($urandom);
      end
      issue(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), v1, v2);
      consume($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/execute_scheduler.md
EXECUTE_SCHEDULER -- requirements
Module: execute_scheduler

Interface
REQ-001 Parameter vecSize, default 4, number of lanes per vector.
REQ-002 Parameter regSize, default 8, bits per lane.
REQ-003 The block SHALL provide these ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; low forces the reset state immediately.
- flush  in  1  synchronous abort of in-flight operation.
- in_valid  in  1  issue request.
- in_ready  out  1  scheduler accepts issue this cycle.
- ExecuteOp  in  3  opcode.
- pcWrEn  in  3  [2] unconditional jump, [1] jump-if-Z, [0] jump-if-N.
- overwriteFlags  in  1  op updates NZ_flags.
- vect1, vect2  in  vecSize x regSize  operand vectors.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- vectOut  out  vecSize x regSize  result vector.
- pcWrEnOut  out  1  branch taken, qualified by out_valid.
- NZ_flags  out  2  [1]=N, [0]=Z, architectural flags.
- busy  out  1  high in MUL or OUT state.

Function
REQ-004 Issue handshake SHALL be in_valid && in_ready at a rising edge; ExecuteOp, pcWrEn, overwriteFlags, vect1 and vect2 SHALL be captured on that edge.
REQ-005 Per-lane operations: 000 pass vect1; 001 XOR; 010 add; 011 subtract vect1-vect2; 100 multiply; 101 logical shift right by vect2 lane; 110 logical shift left by vect2 lane; 111 pass vect2.
REQ-006 Arithmetic SHALL wrap modulo 2^regSize per lane, with no inter-lane carry. Multiply SHALL keep the low regSize bits of the product.
REQ-007 A shift amount >= regSize SHALL yield 0.
REQ-008 FSM states SHALL be IDLE, MUL and OUT.
REQ-009 IDLE -> OUT on accepting a non-multiply op; the result SHALL be registered on the accept edge (out_valid high 1 cycle after accept).
REQ-010 IDLE -> MUL on accepting op 100. One shared regSize x regSize multiplier SHALL process lane 0..vecSize-1, one lane per cycle, using a lane counter.
REQ-011 MUL -> OUT on the edge that writes lane vecSize-1; out_valid SHALL be high vecSize cycles after accept.
REQ-012 OUT holds vectOut and pcWrEnOut stable until out_valid && out_ready.
- On that edge, OUT -> IDLE if no issue.
- Otherwise a simultaneous issue is accepted back-to-back (next state OUT or MUL).
REQ-013 in_ready SHALL equal (state==IDLE) || (state==OUT && out_ready) and SHALL be low in MUL and while flush is high.
REQ-014 Result flags SHALL be: N = OR of all lane MSBs; Z = all lanes zero.
REQ-015 When overwriteFlags=1, NZ_flags SHALL be loaded with the result flags on the edge the result is registered (the final lane edge for MUL). Otherwise NZ_flags SHALL be unchanged.
REQ-016 pcWrEnOut SHALL equal pcWrEn[2] | (pcWrEn[1] & Z) | (pcWrEn[0] & N).
- Z and N are the op's own result flags if overwriteFlags=1, else NZ_flags prior to the op.
- pcWrEnOut SHALL be 0 whenever out_valid=0.
REQ-017 When flush=1 at an edge, state -> IDLE, out_valid -> 0, lane counter -> 0. NZ_flags SHALL be unchanged and no issue is accepted. A MUL flushed mid-lane SHALL NOT update flags.
REQ-018 busy SHALL equal (state != IDLE).

Reset
REQ-019 While reset=0: state IDLE, lane counter 0, out_valid 0, vectOut all 0, pcWrEnOut 0, NZ_flags 00, busy 0. in_ready SHALL be 0 while reset is asserted.
REQ-020 Reset SHALL act asynchronously on assertion; its release is used synchronously. Reset asserted mid-MUL SHALL discard the operation.

Verification
REQ-021 XOR, vect1={55,AA,CC,33}, vect2={AA,55,F0,0F} (lane3..0 hex), out_ready=1 -> one cycle later out_valid=1, vectOut={FF,FF,3C,3C}, NZ_flags=10.
REQ-022 MUL, vect1={05,0A,0C,03}, vect2={0A,05,00,0F} -> in_ready low 4 cycles; vectOut={32,32,00,2D} exactly 4 cycles after accept.
REQ-023 SUB with vect1==vect2, overwriteFlags=1, pcWrEn=010 -> vectOut=0, NZ_flags=01, pcWrEnOut=1. The same op with overwriteFlags=0 after a negative result -> pcWrEnOut=0.
REQ-024 Backpressure: out_ready=0 for 3 cycles with in_valid held -> vectOut stable, no second accept. Raising out_ready -> completion and accept occur on the same edge, next result valid 1 cycle later.
REQ-025 Flush in MUL cycle 2 -> out_valid stays 0, NZ_flags unchanged, in_ready=1 next cycle. Reset low mid-MUL -> all outputs reach the REQ-019 values with no clock edge.
REQ-026 SHR by {04,03,02,01} on {0F,F0,55,AA} -> {00,1E,15,55}. SHL by a lane value of 08 -> that lane 00.
